// File: rtl/adder_arbiter_if.sv
// Handshake and operand bundle between the requesters/consumer and the
// shared-adder arbiter. The arbiter is the slave side; whoever drives the
// requests and consumes the results is the master side.
interface adder_arbiter_if #(
   parameter int WIDTH   = 8,
   parameter int NUM_REQ = 4
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]       i_req;
   logic [NUM_REQ*WIDTH-1:0] i_add1;
   logic [NUM_REQ*WIDTH-1:0] i_add2;
   logic [NUM_REQ-1:0]       o_gnt;
   logic                     o_valid;
   logic                     i_ready;
   logic [WIDTH:0]           o_result;
   logic [ID_W-1:0]          o_id;
   logic                     o_busy;

   modport slave (
      input  i_req, i_add1, i_add2, i_ready,
      output o_gnt, o_valid, o_result, o_id, o_busy
   );

   modport master (
      output i_req, i_add1, i_add2, i_ready,
      input  o_gnt, o_valid, o_result, o_id, o_busy
   );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one unsigned adder among NUM_REQ requesters.
// Two pipeline stages: S1 holds the granted operands, S2 holds the sum.
// Grants are only issued when S1 can take a new operation, so a granted
// request is always accepted in the same cycle.
module adder_arbiter #(
   parameter int WIDTH   = 8,
   parameter int NUM_REQ = 4
) (
   input logic           i_clk,
   input logic           i_rst_n,
   adder_arbiter_if.slave bus
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic              v1;
   logic              v2;
   logic [ID_W-1:0]   ptr;
   logic [WIDTH-1:0]  s1_a;
   logic [WIDTH-1:0]  s1_b;
   logic [ID_W-1:0]   s1_id;
   logic [WIDTH:0]    s2_sum;
   logic [ID_W-1:0]   s2_id;

   logic              advance1;
   logic              advance2;
   logic              found;
   logic              accept;
   logic [ID_W-1:0]   win;
   logic [ID_W-1:0]   ptr_next;
   logic [ID_W:0]     scan_idx;
   logic [WIDTH:0]    adder_sum;

   assign advance2 = !v2 | bus.i_ready;
   assign advance1 = !v1 | advance2;

   // Round-robin search: first requester at or after ptr, wrapping past the top
   always_comb begin
      found    = 1'b0;
      win      = '0;
      scan_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = {1'b0, ptr} + (ID_W+1)'(i);
         if (scan_idx >= (ID_W+1)'(NUM_REQ))
            scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
         if (!found && bus.i_req[scan_idx[ID_W-1:0]]) begin
            found = 1'b1;
            win   = scan_idx[ID_W-1:0];
         end
      end
   end

   // One-hot grant, suppressed while S1 is blocked or reset is asserted
   always_comb begin
      bus.o_gnt = '0;
      if (i_rst_n && advance1 && found)
         bus.o_gnt[win] = 1'b1;
   end

   assign accept   = |(bus.i_req & bus.o_gnt);
   assign ptr_next = (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;

   // The single shared adder; the extra bit keeps the carry out
   assign adder_sum = {1'b0, s1_a} + {1'b0, s1_b};

   // Valid bits and the round-robin pointer, cleared asynchronously
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v1  <= 1'b0;
         v2  <= 1'b0;
         ptr <= '0;
      end else begin
         if (advance1)
            v1 <= accept;
         if (advance2)
            v2 <= v1;
         if (accept)
            ptr <= ptr_next;
      end
   end

   // Stage data registers; their contents only matter when the valid bit is set
   always_ff @(posedge i_clk) begin
      if (accept) begin
         s1_a  <= bus.i_add1[win*WIDTH +: WIDTH];
         s1_b  <= bus.i_add2[win*WIDTH +: WIDTH];
         s1_id <= win;
      end
      if (advance2) begin
         s2_sum <= adder_sum;
         s2_id  <= s1_id;
      end
   end

   assign bus.o_valid  = v2;
   assign bus.o_result = s2_sum;
   assign bus.o_id     = s2_id;
   assign bus.o_busy   = v1 | v2;
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-003 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_req  input  NUM_REQ  per-requester request, bit k = requester k.
REQ-006 SHALL have port i_add1  input  NUM_REQ*WIDTH  packed operand A, slice k = [k*WIDTH +: WIDTH].
REQ-007 SHALL have port i_add2  input  NUM_REQ*WIDTH  packed operand B, same slicing.
REQ-008 SHALL have port o_gnt  output  NUM_REQ  one-hot grant, combinational.
REQ-009 SHALL have port o_valid  output  1  result valid.
REQ-010 SHALL have port i_ready  input  1  downstream accepts result.
REQ-011 SHALL have port o_result  output  WIDTH+1  unsigned sum, MSB = carry out.
REQ-012 SHALL have port o_id  output  max(1,$clog2(NUM_REQ))  index of requester owning o_result.
REQ-013 SHALL have port o_busy  output  1  high when any pipeline stage holds an operation.

Function
REQ-014 SHALL share one unsigned WIDTH-bit adder (lpm_add_sub, direction ADD, cout used) among all requesters.
REQ-015 SHALL implement two stages: S1 = operand register {a, b, id, v1}; S2 = result register {sum, id, v2}.
REQ-016 SHALL define advance2 = !v2 | i_ready; advance1 = !v1 | advance2.
REQ-017 SHALL assert o_gnt only when advance1 is high; o_gnt = 0 otherwise.
REQ-018 SHALL select winner round-robin: first set i_req bit at or after pointer ptr, scanning upward with wrap from NUM_REQ-1 to 0.
REQ-019 SHALL treat accept = |(i_req & o_gnt); requester k holds i_req[k] and operands stable until granted.
REQ-020 SHALL on accept load S1 with slice k operands and id k, set v1; on advance1 without accept clear v1.
REQ-021 SHALL on accept set ptr = (k+1) mod NUM_REQ; ptr unchanged otherwise.
REQ-022 SHALL on advance2 load S2 with {adder(S1.a, S1.b), S1.id, v1}; hold S2 when !advance2.
REQ-023 SHALL drive o_valid = v2, o_result = S2.sum, o_id = S2.id; latency accept -> o_valid = 2 cycles with i_ready high.
REQ-024 SHALL hold o_result and o_id stable while o_valid & !i_ready.
REQ-025 SHALL sustain one accept per cycle when i_ready is held high.
REQ-026 SHALL compute o_result = i_add1_k + i_add2_k exactly, width WIDTH+1, no truncation (e.g. 8'hFF+8'hFF = 9'h1FE).
REQ-027 SHALL ignore i_req bits outside the granted one; no request is lost or duplicated.
REQ-028 SHALL drive o_busy = v1 | v2.

Reset
REQ-029 SHALL on i_rst_n low immediately clear v1, v2, ptr = 0; o_valid = 0, o_busy = 0, o_gnt = 0 while in reset.
REQ-030 SHALL discard in-flight operations on reset mid-operation; S1/S2 data registers need not be reset.
REQ-031 SHALL resume arbitration from ptr = 0 on the first clock edge after i_rst_n deasserts.

Verification (WIDTH=8, NUM_REQ=4)
REQ-032 Single: i_req=4'b0100, A2=8'h12, B2=8'h34, i_ready=1 -> o_gnt=4'b0100 same cycle; two cycles later o_valid=1, o_result=9'h046, o_id=2.
REQ-033 Carry: requester 0 A=8'hFF, B=8'h01 -> o_result=9'h100; A=8'hFF, B=8'hFF -> 9'h1FE.
REQ-034 Fairness: i_req=4'b1111 held, i_ready=1, from reset -> grant order 0,1,2,3,0,...; o_id sequence matches, one result per cycle.
REQ-035 Backpressure: i_req=4'b1111, i_ready=0 -> two accepts (ids 0,1), then o_gnt=0; o_result/o_id frozen at id 0; release i_ready -> ids 0,1,2... delivered in order, none lost.
REQ-036 Reset mid-flight: assert i_rst_n=0 with v1=v2=1 -> o_valid, o_busy drop asynchronously; after release, i_req=4'b1000 -> grant to 3, result correct, no stale output.
REQ-037 Random: constrained-random requests/operands/i_ready, scoreboard per id checks every sum exact, in-order, each request served exactly once.
